// File: rtl/countdown_overlay_sprite.sv
// -----------------------------------------------------------------------------
// countdown_overlay_sprite
//
// Countdown overlay for the VGA race screen. A small sequencer steps a digit
// from START_VAL down to 1, holding each digit for TICKS clocks, and renders
// the current digit as a seven-segment glyph inside a fixed box on screen.
// While paused the glyph blinks with a half period of BLINK clocks; abort
// drops straight back to idle without a done pulse.
//
// Ports
//   clk        system clock
//   rst        synchronous, active-high reset
//   start      begin a countdown (only honoured in IDLE)
//   pause      level; freezes the countdown while high
//   abort      return to IDLE immediately, no done
//   h_cnt      VGA horizontal pixel counter
//   v_cnt      VGA vertical pixel counter
//   is_pixel   registered; colour the pixel at the previous cycle's h/v
//   busy       high while counting or held
//   cur_digit  digit currently shown, 0 when idle
//   done       one-cycle pulse when the last digit expires
// -----------------------------------------------------------------------------
module countdown_overlay_sprite #(
    parameter int unsigned X0        = 290,
    parameter int unsigned Y0        = 190,
    parameter int unsigned W         = 60,
    parameter int unsigned H         = 100,
    parameter int unsigned S         = 20,
    parameter int unsigned START_VAL = 3,
    parameter int unsigned TICKS     = 100_000_000,
    parameter int unsigned BLINK     = 25_000_000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       pause,
    input  logic       abort,
    input  logic [9:0] h_cnt,
    input  logic [9:0] v_cnt,
    output logic       is_pixel,
    output logic       busy,
    output logic [3:0] cur_digit,
    output logic       done
);

    // Counter widths; a one-state counter still needs a 1-bit register.
    localparam int unsigned TW = (TICKS > 1) ? $clog2(TICKS) : 1;
    localparam int unsigned BW = (BLINK > 1) ? $clog2(BLINK) : 1;

    localparam logic [TW-1:0] TICK_LAST = TW'(TICKS - 1);
    localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK - 1);
    localparam logic [3:0]    START_DIG = 4'(START_VAL);

    // Box bounds are kept 11 bits wide so X0+W / Y0+H cannot wrap.
    localparam logic [10:0] X_LO = 11'(X0);
    localparam logic [10:0] X_HI = 11'(X0 + W);
    localparam logic [10:0] Y_LO = 11'(Y0);
    localparam logic [10:0] Y_HI = 11'(Y0 + H);

    localparam logic [9:0] X0_10   = 10'(X0);
    localparam logic [9:0] Y0_10   = 10'(Y0);
    localparam logic [9:0] S_10    = 10'(S);
    localparam logic [9:0] G_LO    = 10'((H - S) / 2);
    localparam logic [9:0] G_HI    = 10'((H + S) / 2);
    localparam logic [9:0] D_LO    = 10'(H - S);
    localparam logic [9:0] HALF_H  = 10'(H / 2);
    localparam logic [9:0] RIGHT_X = 10'(W - S);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_COUNT,
        ST_HOLD
    } state_t;

    state_t          state_q, state_d;
    logic [TW-1:0]   tick_q, tick_d;
    logic [BW-1:0]   blink_q, blink_d;
    logic            phase_q, phase_d;   // 1 = glyph visible while held
    logic [3:0]      digit_q, digit_d;
    logic            done_q, done_d;
    logic            pix_q, pix_d;
    logic            step_en;

    // ---------------------------------------------------------------------
    // Glyph geometry
    // ---------------------------------------------------------------------
    logic       in_box;
    logic [9:0] rx, ry;
    logic [6:0] seg_on;    // {a,b,c,d,e,f,g} lit for the current digit
    logic [6:0] seg_at;    // {a,b,c,d,e,f,g} covering the current pixel
    logic       seg_hit;

    always_comb begin
        in_box = ({1'b0, h_cnt} >= X_LO) && ({1'b0, h_cnt} < X_HI) &&
                 ({1'b0, v_cnt} >= Y_LO) && ({1'b0, v_cnt} < Y_HI);
        rx = h_cnt - X0_10;
        ry = v_cnt - Y0_10;

        seg_at[6] = (ry < S_10);                          // a
        seg_at[5] = (rx >= RIGHT_X) && (ry < HALF_H);     // b
        seg_at[4] = (rx >= RIGHT_X) && (ry >= HALF_H);    // c
        seg_at[3] = (ry >= D_LO);                         // d
        seg_at[2] = (rx < S_10) && (ry >= HALF_H);        // e
        seg_at[1] = (rx < S_10) && (ry < HALF_H);         // f
        seg_at[0] = (ry >= G_LO) && (ry < G_HI);          // g

        unique case (digit_q)
            4'd1:    seg_on = 7'b0110000;
            4'd2:    seg_on = 7'b1101101;
            4'd3:    seg_on = 7'b1111001;
            4'd4:    seg_on = 7'b0110011;
            4'd5:    seg_on = 7'b1011011;
            4'd6:    seg_on = 7'b1011111;
            4'd7:    seg_on = 7'b1110000;
            4'd8:    seg_on = 7'b1111111;
            4'd9:    seg_on = 7'b1111011;
            default: seg_on = 7'b0000000;
        endcase

        seg_hit = |(seg_on & seg_at);
    end

    // ---------------------------------------------------------------------
    // Sequencer next state
    // ---------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        tick_d  = tick_q;
        blink_d = blink_q;
        phase_d = phase_q;
        digit_d = digit_q;
        done_d  = 1'b0;
        step_en = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (!abort && start) begin
                    state_d = ST_COUNT;
                    digit_d = START_DIG;
                    tick_d  = '0;
                end
            end
            ST_COUNT: begin
                if (abort) begin
                    state_d = ST_IDLE;
                    digit_d = '0;
                end else if (pause) begin
                    state_d = ST_HOLD;
                    blink_d = '0;
                    phase_d = 1'b1;
                end else begin
                    step_en = 1'b1;
                end
            end
            ST_HOLD: begin
                if (abort) begin
                    state_d = ST_IDLE;
                    digit_d = '0;
                end else if (!pause) begin
                    // The release cycle already counts, so a pause of N
                    // cycles delays the next step by exactly N cycles.
                    state_d = ST_COUNT;
                    step_en = 1'b1;
                end else if (blink_q == BLINK_LAST) begin
                    blink_d = '0;
                    phase_d = ~phase_q;
                end else begin
                    blink_d = blink_q + BW'(1);
                end
            end
            default: state_d = ST_IDLE;
        endcase

        if (step_en) begin
            if (tick_q == TICK_LAST) begin
                tick_d = '0;
                if (digit_q > 4'd1) begin
                    digit_d = digit_q - 4'd1;
                end else begin
                    done_d  = 1'b1;
                    state_d = ST_IDLE;
                    digit_d = '0;
                end
            end else begin
                tick_d = tick_q + TW'(1);
            end
        end

        pix_d = in_box && (state_q != ST_IDLE) && seg_hit &&
                ((state_q != ST_HOLD) || phase_q);
    end

    // ---------------------------------------------------------------------
    // State registers
    // ---------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            tick_q  <= '0;
            blink_q <= '0;
            phase_q <= 1'b1;
            digit_q <= '0;
            done_q  <= 1'b0;
            pix_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            tick_q  <= tick_d;
            blink_q <= blink_d;
            phase_q <= phase_d;
            digit_q <= digit_d;
            done_q  <= done_d;
            pix_q   <= pix_d;
        end
    end

    assign busy      = (state_q != ST_IDLE);
    assign cur_digit = digit_q;
    assign done      = done_q;
    assign is_pixel  = pix_q;

endmodule

// File: tb/tb_countdown_overlay_sprite.sv
// -----------------------------------------------------------------------------
// tb_countdown_overlay_sprite
//
// Self-checking bench for countdown_overlay_sprite with TICKS=10, BLINK=4.
// A reference model tracks "counting clocks left until done" and "cycles
// spent paused" and derives the shown digit and blink phase from those.
// -----------------------------------------------------------------------------
module tb_countdown_overlay_sprite;

    localparam int X0 = 290;
    localparam int Y0 = 190;
    localparam int W  = 60;
    localparam int H  = 100;
    localparam int S  = 20;
    localparam int START_VAL = 3;
    localparam int TICKS = 10;
    localparam int BLINK = 4;

    logic       clk = 1'b0;
    logic       rst, start, pause, abort;
    logic [9:0] h_cnt, v_cnt;
    logic       is_pixel, busy, done;
    logic [3:0] cur_digit;

    countdown_overlay_sprite #(
        .X0(X0), .Y0(Y0), .W(W), .H(H), .S(S),
        .START_VAL(START_VAL), .TICKS(TICKS), .BLINK(BLINK)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .pause(pause), .abort(abort),
        .h_cnt(h_cnt), .v_cnt(v_cnt),
        .is_pixel(is_pixel), .busy(busy), .cur_digit(cur_digit), .done(done)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model state
    bit m_busy, m_paused, m_done, m_pix;
    int m_left, m_hold;

    string seg_tbl [0:9] = '{"", "bc", "abged", "abgcd", "fgbc", "afgcd",
                             "afgecd", "abc", "abcdefg", "abcdfg"};

    typedef struct {
        int h;
        int v;
        bit exp_pix;
    } rvec_t;
    rvec_t rtab [6];

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int m_digit();
        return m_busy ? (m_left + TICKS - 1) / TICKS : 0;
    endfunction

    function automatic bit glyph_hit(input int d, input int h, input int v);
        int rx, ry;
        bit hit;
        string segs;
        if (h < X0 || h >= X0 + W || v < Y0 || v >= Y0 + H) return 1'b0;
        rx = h - X0;
        ry = v - Y0;
        segs = seg_tbl[d];
        hit = 1'b0;
        for (int i = 0; i < segs.len(); i++) begin
            case (segs.getc(i))
                "a": hit |= (ry < S);
                "b": hit |= (rx >= W - S && ry < H / 2);
                "c": hit |= (rx >= W - S && ry >= H / 2);
                "d": hit |= (ry >= H - S);
                "e": hit |= (rx < S && ry >= H / 2);
                "f": hit |= (rx < S && ry < H / 2);
                "g": hit |= (ry >= (H - S) / 2 && ry < (H + S) / 2);
                default: ;
            endcase
        end
        return hit;
    endfunction

    task automatic advance();
        m_left--;
        if (m_left == 0) begin
            m_done = 1'b1;
            m_busy = 1'b0;
        end
    endtask

    // Apply the rules for one clock edge using the inputs currently driven.
    task automatic model_edge();
        bit visible;
        visible = !m_paused || ((m_hold / BLINK) % 2 == 0);
        m_pix  = !rst && m_busy && visible && glyph_hit(m_digit(), int'(h_cnt), int'(v_cnt));
        m_done = 1'b0;
        if (rst) begin
            m_busy = 1'b0; m_paused = 1'b0; m_left = 0; m_hold = 0;
        end else if (!m_busy) begin
            if (start && !abort) begin
                m_busy = 1'b1; m_paused = 1'b0; m_left = START_VAL * TICKS;
            end
        end else if (abort) begin
            m_busy = 1'b0; m_paused = 1'b0;
        end else if (!m_paused) begin
            if (pause) begin
                m_paused = 1'b1; m_hold = 0;
            end else begin
                advance();
            end
        end else if (!pause) begin
            m_paused = 1'b0;
            advance();
        end else begin
            m_hold++;
        end
    endtask

    task automatic cyc();
        model_edge();
        @(posedge clk);
        #1;
        chk("model_digit", int'(cur_digit), m_digit());
        chk("model_busy", int'(busy), int'(m_busy));
        chk("model_done", int'(done), int'(m_done));
        chk("model_pixel", int'(is_pixel), int'(m_pix));
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) cyc();
    endtask

    task automatic do_start();
        start = 1'b1;
        cyc();
        start = 1'b0;
    endtask

    int  exp_d;
    bit  saw_done;

    initial begin
        rtab[0] = '{335, 200, 1'b1};
        rtab[1] = '{300, 200, 1'b0};
        rtab[2] = '{289, 200, 1'b0};
        rtab[3] = '{349, 289, 1'b1};
        rtab[4] = '{350, 289, 1'b0};
        rtab[5] = '{335, 290, 1'b0};

        m_busy = 0; m_paused = 0; m_done = 0; m_pix = 0; m_left = 0; m_hold = 0;
        rst = 1'b1; start = 1'b0; pause = 1'b0; abort = 1'b0;
        h_cnt = 10'd335; v_cnt = 10'd200;
        run(2);
        chk("reset_busy", int'(busy), 0);
        chk("reset_digit", int'(cur_digit), 0);
        chk("reset_done", int'(done), 0);
        chk("reset_pixel", int'(is_pixel), 0);
        rst = 1'b0;
        run(2);

        // Basic count: digit 3,2,1 for ten edges each, done after edge 30
        do_start();
        chk("basic_first", int'(cur_digit), 3);
        for (int n = 1; n <= 31; n++) begin
            cyc();
            exp_d = (n < 10) ? 3 : (n < 20) ? 2 : (n < 30) ? 1 : 0;
            chk("basic_digit", int'(cur_digit), exp_d);
            chk("basic_done", int'(done), (n == 30) ? 1 : 0);
            chk("basic_busy", int'(busy), (n < 30) ? 1 : 0);
        end

        // Render with digit 1 shown
        h_cnt = 10'd0; v_cnt = 10'd0;
        do_start();
        run(20);
        for (int i = 0; i < 6; i++) begin
            h_cnt = 10'(rtab[i].h);
            v_cnt = 10'(rtab[i].v);
            cyc();
            chk("render_table", int'(is_pixel), int'(rtab[i].exp_pix));
        end
        run(10);
        chk("render_idle_after", int'(busy), 0);

        // Pause at tick 4 for 7 cycles; glyph blinks with period 8
        h_cnt = 10'd335; v_cnt = 10'd200;
        do_start();
        run(4);
        pause = 1'b1;
        run(4);                                   // edges 5..8
        chk("pause_visible", int'(is_pixel), 1);  // hold cycle 2
        cyc();                                    // edge 9
        chk("pause_visible_last", int'(is_pixel), 1);
        cyc();                                    // edge 10
        chk("pause_blank", int'(is_pixel), 0);
        chk("pause_digit_held", int'(cur_digit), 3);
        cyc();                                    // edge 11
        pause = 1'b0;
        run(5);                                   // edges 12..16
        chk("pause_before_step", int'(cur_digit), 3);
        cyc();                                    // edge 17
        chk("pause_step_delayed", int'(cur_digit), 2);
        run(25);

        // Abort at edge 15, no done afterwards
        do_start();
        run(14);
        abort = 1'b1;
        cyc();
        abort = 1'b0;
        chk("abort_digit", int'(cur_digit), 0);
        chk("abort_busy", int'(busy), 0);
        saw_done = 1'b0;
        for (int i = 0; i < 30; i++) begin
            cyc();
            if (done) saw_done = 1'b1;
        end
        chk("abort_no_done", int'(saw_done), 0);
        start = 1'b1; abort = 1'b1;
        cyc();
        start = 1'b0; abort = 1'b0;
        chk("start_abort_idle", int'(busy), 0);
        chk("start_abort_digit", int'(cur_digit), 0);

        // Start during COUNT does not reload
        do_start();
        run(11);
        start = 1'b1;
        cyc();
        start = 1'b0;
        chk("restart_ignored", int'(cur_digit), 2);
        run(20);

        // Reset while held, then a fresh count
        do_start();
        run(3);
        pause = 1'b1;
        run(3);
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        pause = 1'b0;
        chk("rst_hold_pixel", int'(is_pixel), 0);
        chk("rst_hold_busy", int'(busy), 0);
        chk("rst_hold_digit", int'(cur_digit), 0);
        chk("rst_hold_done", int'(done), 0);
        do_start();
        chk("rst_fresh_start", int'(cur_digit), START_VAL);
        run(35);

        // Randomised traffic against the model
        for (int i = 0; i < 3000; i++) begin
            start = ($urandom_range(0, 7) == 0);
            abort = ($urandom_range(0, 79) == 0);
            rst   = ($urandom_range(0, 499) == 0);
            if ($urandom_range(0, 9) == 0) pause = ~pause;
            h_cnt = 10'(X0 - 4 + int'($urandom_range(0, W + 8)));
            v_cnt = 10'(Y0 - 4 + int'($urandom_range(0, H + 8)));
            cyc();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
